hazard_ctrl: RTL
================

Name: hazard_ctrl

Overview:
- Scoreboard-based issue controller for the 5-stage in-order pipeline. Sits between the decode stage and the decode→exec register.
- Tracks in-flight register writes and stalls decode on RAW hazards.
- Squashes wrong-path work on taken branches and sequences the end-of-program drain/halt triggered by finish (SYSTEM/illegal) instructions.
- Its outputs drive the fetch-PC enable, the fetch→decode register enable/clear and the decode→exec register clear.

Parameters:
- REG_COUNT, 32, number of architectural registers (x0 hardwired zero)
- REG_SIZE, 5, register index width
- CNT_W, 2, width of each per-register pending-write counter

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- validD  in  1  decode holds a real instruction
- rs1D  in  REG_SIZE  source register 1 of decode instruction
- rs2D  in  REG_SIZE  source register 2 of decode instruction
- useRs1D  in  1  instruction reads rs1
- useRs2D  in  1  instruction reads rs2
- rdD  in  REG_SIZE  destination register
- regWriteD  in  1  instruction writes rd
- finishD  in  1  instruction is finish
- branchTakenE  in  1  branch/jump in exec redirects PC this cycle
- validW  in  1  writeback holds a real instruction
- regWriteW  in  1  writeback writes a register
- writeRegW  in  REG_SIZE  writeback destination
- finishW  in  1  finish instruction reached writeback
- stallF  out  1  hold PC
- stallD  out  1  hold fetch→decode register
- flushD  out  1  clear fetch→decode register
- flushE  out  1  load bubble into decode→exec register
- halted  out  1  program finished; pipeline frozen

Behaviour:
- State: pending[REG_COUNT] counters of CNT_W bits, plus FSM {RUN, DRAIN, HALTED}. Reset: all counters 0, state RUN, all outputs 0.
- Outputs are combinational from state and inputs. State updates at posedge clk.
- retireHit(r) = validW & regWriteW & writeRegW==r & r!=0.
- busy(r) = r!=0 & pending[r]!=0 & !(pending[r]==1 & retireHit(r)). The regfile writes on negedge, so a same-cycle retiring value is readable.
- raw = validD & ((useRs1D & busy(rs1D)) | (useRs2D & busy(rs2D))).
- full = validD & regWriteD & rdD!=0 & pending[rdD]==max & !retireHit(rdD).
- In RUN:
  - stall = (raw | full) & !branchTakenE.
  - stallF = stallD = stall.
  - flushE = stall | branchTakenE | !validD.
  - flushD = branchTakenE.
- issue = state==RUN & validD & !stall & !branchTakenE.
- Counter update for each r:
  - +1 if issue & regWriteD & rdD==r & r!=0.
  - −1 if retireHit(r).
  - Both in the same cycle → unchanged.
  - Never wraps: full prevents overflow. A decrement at 0 is a protocol error; the counter holds 0 and a simulation assertion fires.
- x0 counter is permanently 0.
- FSM:
  - RUN→DRAIN when issue & finishD. The finish instruction itself is issued.
  - DRAIN: stallF=stallD=1, flushE=1, flushD=0.
  - If branchTakenE occurs in DRAIN, the finish instruction was wrong-path: assert flushD=1 and return to RUN.
  - DRAIN→HALTED when validW & finishW.
  - HALTED: stallF=stallD=flushE=halted=1, flushD=0. Counters are still decremented by any retirements.
  - HALTED is left only by reset.
- Priority: reset > branchTakenE > stall.
- Reset mid-operation clears all counters and FSM in one cycle, regardless of in-flight state.
- Latency: a dependent instruction issues in the cycle its producer is in W, so a back-to-back dependency stalls 2 cycles. No load-specific handling: every producer is covered by the scoreboard, and there is no forwarding network.

Decomposition:
- Shared package (existing defines header): FSM state enum {HC_RUN, HC_DRAIN, HC_HALTED}, REG_SIZE and REG_COUNT constants.
- One sub-module: hc_scoreboard, holding the counter array, increment/decrement logic, and the busy/full lookups for three read ports (rs1, rs2, rd).
- hazard_ctrl keeps the FSM and output muxing.

Test Plan:
- addi x1,x0,5 then add x2,x1,x1 back-to-back → stallD=1 for exactly 2 cycles, flushE=1 in those cycles, pending[1] 1→0 on x1 writeback, add issues the same cycle x1 is in W.
- addi x1; addi x1; addi x1 (no readers, CNT_W=2) → pending[1] reaches 3. A fourth write to x1 stalls with full until one retires; the counter never wraps.
- Writes to x0 and reads of x0 → pending[0] stays 0, no stall ever.
- branchTakenE=1 while decode holds a RAW-stalled add → flushD=1, flushE=1, stall=0, no counter increment.
- ecall issued with x3 pending → DRAIN. stallF=1 until finishW; halted=1 from the cycle after finishW and stays 1 for 20 cycles.
- reset=1 asserted in DRAIN with pending[5]=2 → next cycle state RUN, all counters 0, all outputs 0.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared constants and state encoding for the issue/hazard controller.
package hazard_ctrl_pkg;

  localparam int REG_SIZE  = 5;
  localparam int REG_COUNT = 32;
  localparam int CNT_W     = 2;

  // Controller phase: normal issue, draining after a finish, frozen.
  typedef enum logic [1:0] {
    HC_RUN,
    HC_DRAIN,
    HC_HALTED
  } hc_state_e;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Decode/writeback sideband into the controller and pipeline-control
// outputs back to fetch/decode/exec.
interface hazard_ctrl_if #(
  parameter int REG_SIZE = hazard_ctrl_pkg::REG_SIZE
);

  // decode-stage instruction
  logic                validD;
  logic [REG_SIZE-1:0] rs1D;
  logic [REG_SIZE-1:0] rs2D;
  logic                useRs1D;
  logic                useRs2D;
  logic [REG_SIZE-1:0] rdD;
  logic                regWriteD;
  logic                finishD;
  // exec redirect
  logic                branchTakenE;
  // writeback retirement
  logic                validW;
  logic                regWriteW;
  logic [REG_SIZE-1:0] writeRegW;
  logic                finishW;
  // pipeline control
  logic                stallF;
  logic                stallD;
  logic                flushD;
  logic                flushE;
  logic                halted;

  // pipeline side: drives instruction info, consumes control
  modport master (
    output validD, rs1D, rs2D, useRs1D, useRs2D, rdD, regWriteD, finishD,
    output branchTakenE, validW, regWriteW, writeRegW, finishW,
    input  stallF, stallD, flushD, flushE, halted
  );

  // controller side
  modport slave (
    input  validD, rs1D, rs2D, useRs1D, useRs2D, rdD, regWriteD, finishD,
    input  branchTakenE, validW, regWriteW, writeRegW, finishW,
    output stallF, stallD, flushD, flushE, halted
  );

endinterface

// File: rtl/hazard_ctrl_scoreboard.sv
// Per-register pending-write counters with busy lookups for two source
// ports and a saturation lookup for the destination port.
module hc_scoreboard
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_COUNT = hazard_ctrl_pkg::REG_COUNT,
  parameter int REG_SIZE  = hazard_ctrl_pkg::REG_SIZE,
  parameter int CNT_W     = hazard_ctrl_pkg::CNT_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                inc_en,     // an instruction with a write issues
  input  logic [REG_SIZE-1:0] inc_reg,
  input  logic                ret_en,     // a register write retires in W
  input  logic [REG_SIZE-1:0] ret_reg,
  input  logic [REG_SIZE-1:0] rs1,
  input  logic [REG_SIZE-1:0] rs2,
  input  logic [REG_SIZE-1:0] rd,
  output logic                busy_rs1,
  output logic                busy_rs2,
  output logic                full_rd
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0]     pending [REG_COUNT];
  logic [REG_COUNT-1:0] ret_hit;
  logic [REG_COUNT-1:0] inc_hit;

  // One-hot decode of retire and issue targets; x0 never matches.
  always_comb begin
    ret_hit = '0;
    inc_hit = '0;
    for (int r = 1; r < REG_COUNT; r++) begin
      ret_hit[r] = ret_en && (ret_reg == REG_SIZE'(r));
      inc_hit[r] = inc_en && (inc_reg == REG_SIZE'(r));
    end
  end

  // A value retiring this cycle is readable (regfile writes on negedge),
  // so the last outstanding write retiring does not count as busy.
  always_comb begin
    busy_rs1 = (rs1 != '0) && (pending[rs1] != '0) &&
               !((pending[rs1] == CNT_ONE) && ret_hit[rs1]);
    busy_rs2 = (rs2 != '0) && (pending[rs2] != '0) &&
               !((pending[rs2] == CNT_ONE) && ret_hit[rs2]);
    full_rd  = (rd != '0) && (pending[rd] == CNT_MAX) && !ret_hit[rd];
  end

  // Counter update; inc+dec together cancel, and a stray decrement at 0 holds.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < REG_COUNT; r++) pending[r] <= '0;
    end else begin
      pending[0] <= '0;
      for (int r = 1; r < REG_COUNT; r++) begin
        case ({inc_hit[r], ret_hit[r]})
          2'b10:   pending[r] <= pending[r] + CNT_ONE;
          2'b01:   if (pending[r] != '0) pending[r] <= pending[r] - CNT_ONE;
          default: ;
        endcase
      end
    end
  end

`ifndef SYNTHESIS
  // Retiring a register that has no outstanding write is a pipeline bug.
  always @(posedge clk) begin
    if (!reset) begin
      for (int r = 1; r < REG_COUNT; r++)
        assert (!(ret_hit[r] && (pending[r] == '0)))
          else $error("hc_scoreboard: retire of x%0d with no pending write", r);
    end
  end
`endif

endmodule

// File: rtl/hazard_ctrl.sv
// Scoreboard-based issue controller: RAW/full stalls, branch squash and
// the finish -> drain -> halt sequence.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_COUNT = hazard_ctrl_pkg::REG_COUNT,
  parameter int REG_SIZE  = hazard_ctrl_pkg::REG_SIZE,
  parameter int CNT_W     = hazard_ctrl_pkg::CNT_W
) (
  input  logic          clk,
  input  logic          reset,
  hazard_ctrl_if.slave  hif
);

  hc_state_e state;
  logic      busy_rs1, busy_rs2, full_rd;
  logic      raw, full, stall, issue;

  hc_scoreboard #(
    .REG_COUNT (REG_COUNT),
    .REG_SIZE  (REG_SIZE),
    .CNT_W     (CNT_W)
  ) u_sb (
    .clk      (clk),
    .reset    (reset),
    .inc_en   (issue && hif.regWriteD),
    .inc_reg  (hif.rdD),
    .ret_en   (hif.validW && hif.regWriteW),
    .ret_reg  (hif.writeRegW),
    .rs1      (hif.rs1D),
    .rs2      (hif.rs2D),
    .rd       (hif.rdD),
    .busy_rs1 (busy_rs1),
    .busy_rs2 (busy_rs2),
    .full_rd  (full_rd)
  );

  // Hazard detection; a taken branch kills the decode instruction, so it
  // overrides any stall.
  always_comb begin
    raw   = hif.validD && ((hif.useRs1D && busy_rs1) || (hif.useRs2D && busy_rs2));
    full  = hif.validD && hif.regWriteD && full_rd;
    stall = (raw || full) && !hif.branchTakenE;
    issue = (state == HC_RUN) && hif.validD && !stall && !hif.branchTakenE;
  end

  // Output muxing by phase; everything is held low while reset is asserted.
  always_comb begin
    hif.stallF = 1'b0;
    hif.stallD = 1'b0;
    hif.flushD = 1'b0;
    hif.flushE = 1'b0;
    hif.halted = 1'b0;
    if (!reset) begin
      case (state)
        HC_RUN: begin
          hif.stallF = stall;
          hif.stallD = stall;
          hif.flushE = stall || hif.branchTakenE || !hif.validD;
          hif.flushD = hif.branchTakenE;
        end
        HC_DRAIN: begin
          // A redirect here means the finish was wrong-path: let fetch
          // follow the branch and squash the decode slot.
          if (hif.branchTakenE) begin
            hif.flushD = 1'b1;
            hif.flushE = 1'b1;
          end else begin
            hif.stallF = 1'b1;
            hif.stallD = 1'b1;
            hif.flushE = 1'b1;
          end
        end
        HC_HALTED: begin
          hif.stallF = 1'b1;
          hif.stallD = 1'b1;
          hif.flushE = 1'b1;
          hif.halted = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Phase FSM: enter drain when a finish issues, halt when it retires.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= HC_RUN;
    end else begin
      case (state)
        HC_RUN:    if (issue && hif.finishD) state <= HC_DRAIN;
        HC_DRAIN: begin
          if (hif.branchTakenE)                state <= HC_RUN;
          else if (hif.validW && hif.finishW)  state <= HC_HALTED;
        end
        HC_HALTED: state <= HC_HALTED;
        default:   state <= HC_RUN;
      endcase
    end
  end

endmodule
